// File: rtl/reglk_pkg.sv
// Shared definitions for the register-lock access guard.
//   REGLK_*_BIT   : bit positions inside one lock byte
//   reglk_byte_t  : decoded view of one lock byte
//   reglk_log_t   : violation log entry {periph, we, addr}
// Packages cannot take parameters, so the log-entry widths are fixed here.
// The guard's ADDR_W and NB_PERIPHERALS defaults are taken from these values.
package reglk_pkg;

    localparam int REGLK_RD_BIT     = 0;
    localparam int REGLK_WR_BIT     = 1;
    localparam int REGLK_STICKY_BIT = 7;

    localparam int REGLK_NB_PERIPH = 3;
    localparam int REGLK_PERIPH_W  = (REGLK_NB_PERIPH > 1) ? $clog2(REGLK_NB_PERIPH) : 1;
    localparam int REGLK_ADDR_W    = 32;

    typedef struct packed {
        logic       sticky;    // bit 7
        logic [4:0] reserved;  // bits 6:2, ignored
        logic       wr_lock;   // bit 1
        logic       rd_lock;   // bit 0
    } reglk_byte_t;

    typedef struct packed {
        logic [REGLK_PERIPH_W-1:0] periph;
        logic                      we;
        logic [REGLK_ADDR_W-1:0]   addr;
    } reglk_log_t;

endpackage

// File: rtl/reglk_log_fifo.sv
// Generic synchronous FIFO used as the violation log.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous flush (pointers return to empty)
//   push_i/data_i : write request; ignored when full unless a pop happens too
//   pop_i         : read request; ignored when empty
//   data_o        : oldest entry, all-zero while empty
//   full_o/empty_o: occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module reglk_log_fifo #(
    parameter int  DEPTH   = 8,
    parameter type entry_t = logic
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   clear_i,
    input  logic   push_i,
    input  entry_t data_i,
    input  logic   pop_i,
    output entry_t data_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    entry_t      mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign do_pop  = pop_i & ~empty_o;
    // When full, a simultaneous pop frees the slot being overwritten.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    assign data_o = empty_o ? entry_t'('0) : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/reglk_access_guard.sv
// Register-lock access guard.
// Checks each peripheral access against that peripheral's lock byte and
// answers allow/deny one cycle after acceptance. Denials are logged in a
// FIFO and counted with a saturating counter.
//   reglk_ctrl_i   : lock bytes, byte k = [8k+7:8k] (bit0 rd, bit1 wr, bit7 sticky)
//   req_*          : access request (valid/ready, periph, we, addr)
//   resp_*         : decision (valid/ready, allow)
//   log_*          : violation log drain (valid/ready, entry, sticky overflow)
//   viol_cnt_o     : saturating count of all denials
//   clear_i        : flushes log, counter and overflow flag (not sticky locks)
// Optional: define REGLK_GUARD_IRQ_EN to add irq_o, a registered flag that
// is high while the log is non-empty or has overflowed.
module reglk_access_guard
    import reglk_pkg::*;
#(
    parameter int NB_PERIPHERALS = REGLK_NB_PERIPH,
    parameter int ADDR_W         = REGLK_ADDR_W,
    parameter int LOG_DEPTH      = 8,
    parameter int CNT_W          = 16,
    localparam int PERIPH_W      = (NB_PERIPHERALS > 1) ? $clog2(NB_PERIPHERALS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [8*NB_PERIPHERALS-1:0] reglk_ctrl_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [PERIPH_W-1:0]         req_periph_i,
    input  logic                        req_we_i,
    input  logic [ADDR_W-1:0]           req_addr_i,
    output logic                        resp_valid_o,
    input  logic                        resp_ready_i,
    output logic                        resp_allow_o,
    output logic                        log_valid_o,
    input  logic                        log_ready_i,
    output reglk_log_t                  log_entry_o,
    output logic                        log_overflow_o,
    output logic [CNT_W-1:0]            viol_cnt_o,
    input  logic                        clear_i
`ifdef REGLK_GUARD_IRQ_EN
    ,
    output logic                        irq_o
`endif
);

    reglk_byte_t [NB_PERIPHERALS-1:0] lock_bytes;
    logic [NB_PERIPHERALS-1:0]        sticky_rd_q;
    logic [NB_PERIPHERALS-1:0]        sticky_wr_q;
    // Padded to a power of two so out-of-range indices read as unlocked;
    // those requests are denied by the range check instead.
    logic [2**PERIPH_W-1:0]           rd_lock;
    logic [2**PERIPH_W-1:0]           wr_lock;

    logic             accept;
    logic             periph_ok;
    logic             deny;
    logic             log_push;
    logic             log_pop;
    logic             log_full;
    logic             log_empty;
    reglk_log_t       push_entry;
    logic             resp_valid_q;
    logic             resp_allow_q;
    logic             overflow_q;
    logic [CNT_W-1:0] viol_cnt_q;

    assign lock_bytes = reglk_ctrl_i;

    always_comb begin
        rd_lock = '0;
        wr_lock = '0;
        for (int k = 0; k < NB_PERIPHERALS; k++) begin
            rd_lock[k] = lock_bytes[k].rd_lock | sticky_rd_q[k];
            wr_lock[k] = lock_bytes[k].wr_lock | sticky_wr_q[k];
        end
    end

    // Sticky bits only ever set; clear_i deliberately leaves them alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_rd_q <= '0;
            sticky_wr_q <= '0;
        end else begin
            for (int k = 0; k < NB_PERIPHERALS; k++) begin
                if (lock_bytes[k].sticky) begin
                    sticky_rd_q[k] <= sticky_rd_q[k] | lock_bytes[k].rd_lock;
                    sticky_wr_q[k] <= sticky_wr_q[k] | lock_bytes[k].wr_lock;
                end
            end
        end
    end

    assign req_ready_o = ~resp_valid_q | resp_ready_i;
    assign accept      = req_valid_i & req_ready_o;
    assign periph_ok   = 32'(req_periph_i) < 32'(NB_PERIPHERALS);
    assign deny        = ~periph_ok |
                         (req_we_i ? wr_lock[req_periph_i] : rd_lock[req_periph_i]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_q <= 1'b0;
            resp_allow_q <= 1'b0;
        end else if (accept) begin
            resp_valid_q <= 1'b1;
            resp_allow_q <= ~deny;
        end else if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_allow_o = resp_allow_q;

    // A denial coinciding with clear_i is dropped entirely.
    assign log_push   = accept & deny & ~clear_i;
    assign log_pop    = log_ready_i & ~log_empty;
    assign push_entry = '{periph: REGLK_PERIPH_W'(req_periph_i),
                          we:     req_we_i,
                          addr:   REGLK_ADDR_W'(req_addr_i)};

    reglk_log_fifo #(
        .DEPTH   (LOG_DEPTH),
        .entry_t (reglk_log_t)
    ) u_log_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (log_push),
        .data_i  (push_entry),
        .pop_i   (log_pop),
        .data_o  (log_entry_o),
        .full_o  (log_full),
        .empty_o (log_empty)
    );

    assign log_valid_o = ~log_empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
            viol_cnt_q <= '0;
        end else if (clear_i) begin
            overflow_q <= 1'b0;
            viol_cnt_q <= '0;
        end else begin
            if (log_push && log_full && !log_pop) overflow_q <= 1'b1;
            if (log_push && (viol_cnt_q != '1))   viol_cnt_q <= viol_cnt_q + CNT_W'(1);
        end
    end

    assign log_overflow_o = overflow_q;
    assign viol_cnt_o     = viol_cnt_q;

`ifdef REGLK_GUARD_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_q <= 1'b0;
        else         irq_q <= ~log_empty | overflow_q;
    end

    assign irq_o = irq_q;
`endif

endmodule

// File: tb/tb_reglk_access_guard.sv
module tb_reglk_access_guard;
    import reglk_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] ctrl;
    logic        req_valid;
    logic        req_ready_o;
    logic [1:0]  req_periph;
    logic        req_we;
    logic [31:0] req_addr;
    logic        resp_valid_o;
    logic        resp_ready;
    logic        resp_allow_o;
    logic        log_valid_o;
    logic        log_ready;
    reglk_log_t  log_entry_o;
    logic        log_overflow_o;
    logic [15:0] viol_cnt_o;
    logic        clear;
`ifdef REGLK_GUARD_IRQ_EN
    logic        irq_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    reglk_access_guard dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .reglk_ctrl_i   (ctrl),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready_o),
        .req_periph_i   (req_periph),
        .req_we_i       (req_we),
        .req_addr_i     (req_addr),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready),
        .resp_allow_o   (resp_allow_o),
        .log_valid_o    (log_valid_o),
        .log_ready_i    (log_ready),
        .log_entry_o    (log_entry_o),
        .log_overflow_o (log_overflow_o),
        .viol_cnt_o     (viol_cnt_o),
        .clear_i        (clear)
`ifdef REGLK_GUARD_IRQ_EN
        ,
        .irq_o          (irq_o)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_resp_valid;
    bit         m_resp_allow;
    int         m_cnt;
    bit         m_ovf;
    bit         m_srd [3];
    bit         m_swr [3];
    reglk_log_t m_log [$];
    bit         m_acc;
    bit         m_deny;
    int         m_p;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_resp_valid = 0;
            m_resp_allow = 0;
            m_cnt        = 0;
            m_ovf        = 0;
            m_log.delete();
            for (int k = 0; k < 3; k++) begin
                m_srd[k] = 0;
                m_swr[k] = 0;
            end
        end else begin
            m_acc = req_valid && (!m_resp_valid || resp_ready);
            m_p   = int'(req_periph);
            if (m_p >= 3)    m_deny = 1;
            else if (req_we) m_deny = ctrl[8*m_p+1] || m_swr[m_p];
            else             m_deny = ctrl[8*m_p]   || m_srd[m_p];

            if (clear) begin
                m_log.delete();
                m_cnt = 0;
                m_ovf = 0;
            end else begin
                if (log_ready && m_log.size() > 0) void'(m_log.pop_front());
                if (m_acc && m_deny) begin
                    if (m_cnt < 65535) m_cnt++;
                    if (m_log.size() < 8)
                        m_log.push_back('{periph: req_periph, we: req_we, addr: req_addr});
                    else
                        m_ovf = 1;
                end
            end

            if (m_acc) begin
                m_resp_valid = 1;
                m_resp_allow = !m_deny;
            end else if (resp_ready) begin
                m_resp_valid = 0;
            end

            for (int k = 0; k < 3; k++) begin
                if (ctrl[8*k+7]) begin
                    m_srd[k] = m_srd[k] || ctrl[8*k];
                    m_swr[k] = m_swr[k] || ctrl[8*k+1];
                end
            end
        end
    end

    always @(negedge clk) begin
        check("req_ready", 64'(req_ready_o), 64'(!m_resp_valid || resp_ready));
        check("resp_valid", 64'(resp_valid_o), 64'(m_resp_valid));
        if (m_resp_valid) check("resp_allow", 64'(resp_allow_o), 64'(m_resp_allow));
        check("log_valid", 64'(log_valid_o), 64'(m_log.size() != 0));
        check("log_entry", 64'(log_entry_o), (m_log.size() != 0) ? 64'(m_log[0]) : 64'd0);
        check("log_overflow", 64'(log_overflow_o), 64'(m_ovf));
        check("viol_cnt", 64'(viol_cnt_o), 64'(m_cnt));
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] p, input logic we, input logic [31:0] a);
        req_valid  = 1;
        req_periph = p;
        req_we     = we;
        req_addr   = a;
        cyc();
        req_valid  = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 0; ctrl = '0; req_valid = 0; req_periph = '0; req_we = 0;
        req_addr = '0; resp_ready = 1; log_ready = 0; clear = 0;
        repeat (2) cyc();
        mid();
        check("rst_req_ready", 64'(req_ready_o), 64'd1);
        check("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("rst_resp_allow", 64'(resp_allow_o), 64'd0);
        check("rst_log_valid", 64'(log_valid_o), 64'd0);
        check("rst_log_entry", 64'(log_entry_o), 64'd0);
        check("rst_overflow", 64'(log_overflow_o), 64'd0);
        check("rst_viol_cnt", 64'(viol_cnt_o), 64'd0);
        rst_n = 1;

        // Unlocked read
        send(2'd0, 0, 32'h10); mid();
        check("rd0_valid", 64'(resp_valid_o), 64'd1);
        check("rd0_allow", 64'(resp_allow_o), 64'd1);
        check("rd0_cnt", 64'(viol_cnt_o), 64'd0);
        check("rd0_log_valid", 64'(log_valid_o), 64'd0);

        // Write lock on peripheral 1
        ctrl = 24'h000200;
        send(2'd1, 1, 32'h20); mid();
        check("wr1_allow", 64'(resp_allow_o), 64'd0);
        check("wr1_log_valid", 64'(log_valid_o), 64'd1);
        check("wr1_entry", 64'(log_entry_o), 64'h3_0000_0020);
        check("wr1_cnt", 64'(viol_cnt_o), 64'd1);
        send(2'd1, 0, 32'h24); mid();
        check("rd1_allow", 64'(resp_allow_o), 64'd1);
        log_ready = 1; cyc(); log_ready = 0; mid();
        check("pop_log_valid", 64'(log_valid_o), 64'd0);

        // Sticky read lock on peripheral 2
        ctrl = 24'h810000; cyc(); ctrl = '0;
        send(2'd2, 0, 32'h30); mid();
        check("sticky_allow", 64'(resp_allow_o), 64'd0);
        check("sticky_cnt", 64'(viol_cnt_o), 64'd2);
        clear = 1; cyc(); clear = 0; mid();
        check("clr_cnt", 64'(viol_cnt_o), 64'd0);
        check("clr_log_valid", 64'(log_valid_o), 64'd0);
        send(2'd2, 0, 32'h30); mid();
        check("sticky_after_clr", 64'(resp_allow_o), 64'd0);
        check("sticky_after_clr_cnt", 64'(viol_cnt_o), 64'd1);
        rst_n = 0; #2;
        check("arst_resp_valid", 64'(resp_valid_o), 64'd0);
        check("arst_cnt", 64'(viol_cnt_o), 64'd0);
        cyc(); rst_n = 1;
        send(2'd2, 0, 32'h30); mid();
        check("post_rst_allow", 64'(resp_allow_o), 64'd1);

        // Fill and overflow the log
        ctrl = 24'h000001;
        req_valid = 1; req_periph = 2'd0; req_we = 0;
        for (int i = 0; i < 9; i++) begin
            req_addr = 32'h100 + 32'(i);
            cyc();
        end
        req_valid = 0; mid();
        check("ovf_cnt", 64'(viol_cnt_o), 64'd9);
        check("ovf_flag", 64'(log_overflow_o), 64'd1);
        check("ovf_head", 64'(log_entry_o), 64'h100);
        req_valid = 1; req_addr = 32'h200; log_ready = 1;
        cyc();
        req_valid = 0; log_ready = 0; mid();
        check("pushpop_flag", 64'(log_overflow_o), 64'd1);
        check("pushpop_cnt", 64'(viol_cnt_o), 64'd10);
        check("pushpop_head", 64'(log_entry_o), 64'h101);
        n = 0;
        log_ready = 1;
        for (int i = 0; i < 12; i++) begin
            if (log_valid_o) n++;
            mid();
        end
        log_ready = 0;
        check("occupancy", 64'(n), 64'd8);
        clear = 1; cyc(); clear = 0; mid();
        check("clr_ovf", 64'(log_overflow_o), 64'd0);
        check("clr_cnt2", 64'(viol_cnt_o), 64'd0);

        // Response backpressure
        ctrl = 24'h000200;
        resp_ready = 0;
        req_valid = 1; req_periph = 2'd0; req_we = 0; req_addr = 32'h40;
        cyc();
        req_periph = 2'd1; req_we = 1; req_addr = 32'h44;
        for (int i = 0; i < 5; i++) begin
            mid();
            check("stall_ready", 64'(req_ready_o), 64'd0);
            check("stall_valid", 64'(resp_valid_o), 64'd1);
            check("stall_allow", 64'(resp_allow_o), 64'd1);
        end
        resp_ready = 1; #1;
        check("release_ready", 64'(req_ready_o), 64'd1);
        cyc(); req_valid = 0; mid();
        check("release_valid", 64'(resp_valid_o), 64'd1);
        check("release_allow", 64'(resp_allow_o), 64'd0);
        check("release_cnt", 64'(viol_cnt_o), 64'd1);

        // Out-of-range peripheral and counter saturation
        send(2'd3, 0, 32'h50); mid();
        check("oor_allow", 64'(resp_allow_o), 64'd0);
        check("oor_cnt", 64'(viol_cnt_o), 64'd2);
        check("oor_entry_head", 64'(log_entry_o), 64'h3_0000_0044);
        clear = 1; cyc(); clear = 0;
        req_valid = 1; req_periph = 2'd3; req_we = 0; req_addr = 32'h60;
        repeat (65537) cyc();
        req_valid = 0; mid();
        check("sat_cnt", 64'(viol_cnt_o), 64'hFFFF);
        check("sat_ovf", 64'(log_overflow_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
